// File: rtl/br_pkg.sv
// Shared types for the branch resolve queue: op encoding, entry state and
// the per-entry control record. Data-path widths stay with the modules.
package br_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLT  = 3'd2,
        OP_BGE  = 3'd3,
        OP_BLTU = 3'd4,
        OP_BGEU = 3'd5,
        OP_JAL  = 3'd6,
        OP_JALR = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_KILLED = 2'd3
    } br_state_e;

    // Control portion of an entry; operand/PC payloads are kept in
    // parameter-width arrays inside the queue.
    typedef struct packed {
        br_state_e state;
        br_op_e    op;
        logic      rdy1;
        logic      rdy2;
        logic      taken;
    } br_entry_t;

endpackage

// File: rtl/br_cmp.sv
// Branch condition evaluation and next-PC computation for one queue entry.
// Purely combinational; all sums wrap modulo 2^XLEN.
module br_cmp
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] v1,
    input  logic [XLEN-1:0] v2,
    output logic            taken,
    output logic [XLEN-1:0] pc_n
);

    br_op_e          op_e;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] jalr_sum;

    assign op_e     = br_op_e'(op);
    assign target   = pc + offset;
    assign seq_pc   = pc + XLEN'(4);
    assign jalr_sum = v1 + offset;

    // Decide taken and select the matching next PC
    always_comb begin
        taken = 1'b0;
        pc_n  = seq_pc;
        case (op_e)
            OP_BEQ:  taken = (v1 == v2);
            OP_BNE:  taken = (v1 != v2);
            OP_BLT:  taken = ($signed(v1) < $signed(v2));
            OP_BGE:  taken = ($signed(v1) >= $signed(v2));
            OP_BLTU: taken = (v1 < v2);
            OP_BGEU: taken = (v1 >= v2);
            OP_JAL:  taken = 1'b1;
            OP_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (op_e == OP_JALR) begin
            pc_n = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (taken) begin
            pc_n = target;
        end
    end

endmodule

// File: rtl/br_resolve_queue.sv
// Branch resolve queue: holds issued branches/jumps until their operands
// arrive (directly or off the CDB), resolves them out of order and hands
// the results to fetch strictly in issue order. Flushed entries are marked
// killed and silently drained when they reach the head.
// Optional feature macro: BR_MISALIGN_CHK_EN (flags taken targets that are
// not 4-byte aligned on out_misalign).
module br_resolve_queue
    import br_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int THREAD_WIDTH = 2,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    issue_en,
    input  logic [2:0]              issue_op,
    input  logic [XLEN-1:0]         issue_pc,
    input  logic [XLEN-1:0]         issue_offset,
    input  logic [THREAD_WIDTH-1:0] issue_tid,
    input  logic [XLEN-1:0]         issue_v1,
    input  logic [XLEN-1:0]         issue_v2,
    input  logic                    issue_v1_rdy,
    input  logic                    issue_v2_rdy,
    input  logic [TAG_WIDTH-1:0]    issue_q1,
    input  logic [TAG_WIDTH-1:0]    issue_q2,
    input  logic                    cdb_valid,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic                    flush_i,
    input  logic [THREAD_WIDTH-1:0] flush_tid,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [THREAD_WIDTH-1:0] out_tid,
    output logic                    out_taken,
    output logic [XLEN-1:0]         out_pc_n,
    output logic                    out_misalign,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    br_entry_t             ent     [DEPTH];
    logic [XLEN-1:0]       e_pc    [DEPTH];
    logic [XLEN-1:0]       e_off   [DEPTH];
    logic [XLEN-1:0]       e_v1    [DEPTH];
    logic [XLEN-1:0]       e_v2    [DEPTH];
    logic [XLEN-1:0]       e_pcn   [DEPTH];
    logic [TAG_WIDTH-1:0]  e_q1    [DEPTH];
    logic [TAG_WIDTH-1:0]  e_q2    [DEPTH];
    logic [THREAD_WIDTH-1:0] e_tid [DEPTH];
    logic                  cmp_taken [DEPTH];
    logic [XLEN-1:0]       cmp_pcn   [DEPTH];
    logic                  resolve_ok [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic            issue_acc;
    logic            pop;
    logic            head_killed;
    logic [XLEN-1:0] in_v1;
    logic [XLEN-1:0] in_v2;
    logic            in_r1;
    logic            in_r2;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        br_cmp #(.XLEN(XLEN)) u_cmp (
            .op     (ent[g].op),
            .pc     (e_pc[g]),
            .offset (e_off[g]),
            .v1     (e_v1[g]),
            .v2     (e_v2[g]),
            .taken  (cmp_taken[g]),
            .pc_n   (cmp_pcn[g])
        );
    end

    assign full_o      = (count == CW'(DEPTH));
    assign empty_o     = (count == '0);
    assign busy_o      = !empty_o;
    assign issue_acc   = issue_en && !full_o && !stall_i;
    assign head_killed = (ent[rd_ptr].state == ST_KILLED) && !stall_i;

    assign out_valid = (ent[rd_ptr].state == ST_DONE) && !stall_i;
    assign out_tid   = e_tid[rd_ptr];
    assign out_taken = ent[rd_ptr].taken;
    assign out_pc_n  = e_pcn[rd_ptr];
    assign pop       = (out_valid && out_ready) || head_killed;

`ifdef BR_MISALIGN_CHK_EN
    assign out_misalign = out_taken && (out_pc_n[1:0] != 2'b00);
`else
    assign out_misalign = 1'b0;
`endif

    // Operand capture at issue, with same-cycle CDB bypass
    always_comb begin
        in_v1 = issue_v1;
        in_r1 = issue_v1_rdy;
        in_v2 = issue_v2;
        in_r2 = issue_v2_rdy;
        if (!issue_v1_rdy && cdb_valid && (cdb_tag == issue_q1)) begin
            in_v1 = cdb_value;
            in_r1 = 1'b1;
        end
        if (!issue_v2_rdy && cdb_valid && (cdb_tag == issue_q2)) begin
            in_v2 = cdb_value;
            in_r2 = 1'b1;
        end
    end

    // Entries with both operands in hand resolve on the next edge
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            resolve_ok[i] = (ent[i].state == ST_WAIT) && ent[i].rdy1 &&
                            ent[i].rdy2 && !stall_i;
        end
    end

    // Entry array, pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i]   <= '0;
                e_pc[i]  <= '0;
                e_off[i] <= '0;
                e_v1[i]  <= '0;
                e_v2[i]  <= '0;
                e_pcn[i] <= '0;
                e_q1[i]  <= '0;
                e_q2[i]  <= '0;
                e_tid[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // CDB wakeup is not gated by stall so no broadcast is lost
                if (ent[i].state == ST_WAIT) begin
                    if (!ent[i].rdy1 && cdb_valid && (cdb_tag == e_q1[i])) begin
                        e_v1[i]      <= cdb_value;
                        ent[i].rdy1  <= 1'b1;
                    end
                    if (!ent[i].rdy2 && cdb_valid && (cdb_tag == e_q2[i])) begin
                        e_v2[i]      <= cdb_value;
                        ent[i].rdy2  <= 1'b1;
                    end
                end
                if (pop && (PW'(i) == rd_ptr)) begin
                    ent[i].state <= ST_FREE;
                end else if (issue_acc && (PW'(i) == wr_ptr)) begin
                    ent[i]   <= '{state: ST_WAIT, op: br_op_e'(issue_op),
                                  rdy1: in_r1, rdy2: in_r2, taken: 1'b0};
                    e_pc[i]  <= issue_pc;
                    e_off[i] <= issue_offset;
                    e_v1[i]  <= in_v1;
                    e_v2[i]  <= in_v2;
                    e_q1[i]  <= issue_q1;
                    e_q2[i]  <= issue_q2;
                    e_tid[i] <= issue_tid;
                end else if (flush_i && (e_tid[i] == flush_tid) &&
                             ((ent[i].state == ST_WAIT) || (ent[i].state == ST_DONE))) begin
                    ent[i].state <= ST_KILLED;
                end else if (resolve_ok[i]) begin
                    ent[i].state <= ST_DONE;
                    ent[i].taken <= cmp_taken[i];
                    e_pcn[i]     <= cmp_pcn[i];
                end
            end
            if (issue_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(issue_acc) - CW'(pop);
        end
    end

endmodule
